// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, frame
// geometry and the bit-period formula shared with the receiver.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS = 8;
  localparam int BIT_W     = $clog2(DATA_BITS + 1);

  // Bit period in clock cycles, rounded to nearest.
  function automatic int bit_period(input int f, input int baud);
    return (f + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial output of the UART transmitter.
// valid/ready: a byte is accepted at a posedge where valid & ready are both high;
// data_in is sampled only then, and valid is ignored while ready is low.
interface uart_tx_if;
  logic [7:0] data_in;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (output data_in, valid, input ready, tx, busy, done);
  modport slave  (input data_in, valid, output ready, tx, busy, done);
endinterface

// File: rtl/uart_tx_counter.sv
// Modulo-N counter with synchronous clear; ov flags the enabled wrap cycle.
module uart_tx_counter #(
  parameter int N = 2,
  parameter int W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         ce_i,
  output logic [W-1:0] q_o,
  output logic         ov_o
);

  logic [W-1:0] q_q;

  assign ov_o = ce_i && (q_q == W'(N - 1));
  assign q_o  = q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (clr_i || ov_o) begin
      q_q <= '0;
    end else if (ce_i) begin
      q_q <= q_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte over valid/ready and shifts it out
// LSB-first with one start and one stop bit, each bit lasting N clock cycles.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int F    = 8000000,
  parameter int BAUD = 115200
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_if.slave         bus,
  output tx_state_e        dbg_state_o,
  output logic [BIT_W-1:0] dbg_bit_o
);

  localparam int N  = bit_period(F, BAUD);
  localparam int DW = $clog2(N + 1);

  if (N < 2) begin : g_n_check
    $error("uart_tx: bit period N must be >= 2");
  end

  tx_state_e        state_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             ready_q;
  logic             done_q;
  logic             accept;
  logic [DW-1:0]    div_q;
  logic             div_ov;
  logic [BIT_W-1:0] bit_q;
  logic             bit_ov;

  assign accept = bus.valid && ready_q;

  // Restarting the divider on accept makes the start bit exactly N cycles long.
  uart_tx_counter #(.N(N), .W(DW)) u_div (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (accept),
    .ce_i  (1'b1),
    .q_o   (div_q),
    .ov_o  (div_ov)
  );

  uart_tx_counter #(.N(DATA_BITS), .W(BIT_W)) u_bit (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (accept),
    .ce_i  (div_ov && (state_q == ST_DATA)),
    .q_o   (bit_q),
    .ov_o  (bit_ov)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shift_q <= bus.data_in;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (div_ov) begin
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (div_ov) begin
            shift_q <= shift_q >> 1;
            if (bit_ov) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
        ST_STOP: begin
          // Raised one cycle early so the registered pulse lands in the last stop cycle.
          if (div_q == DW'(N - 2)) begin
            done_q <= 1'b1;
          end
          if (div_ov) begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx      = tx_q;
  assign bus.ready   = ready_q;
  assign bus.busy    = ~ready_q;
  assign bus.done    = done_q;
  assign dbg_state_o = state_q;
  assign dbg_bit_o   = bit_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: randomized and directed frames on a fast instance (N=4)
// checked by a line monitor against an ideal 8N1 waveform, plus one default-rate frame.
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int N  = 4;
  localparam int FL = 10 * N;
  localparam int ND = 69;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_if bus ();
  uart_tx_if bus_d ();
  tx_state_e        dbg_state, dbg_state_d;
  logic [BIT_W-1:0] dbg_bit, dbg_bit_d;

  uart_tx #(.F(16), .BAUD(4)) u_dut (
    .clk(clk), .rst(rst_n), .bus(bus), .dbg_state_o(dbg_state), .dbg_bit_o(dbg_bit)
  );

  uart_tx u_dut_def (
    .clk(clk), .rst(rst_n), .bus(bus_d), .dbg_state_o(dbg_state_d), .dbg_bit_o(dbg_bit_d)
  );

  logic [7:0] exp_q[$];
  int         acc_q[$];
  int         start_log[$];
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line monitor: ideal waveform is start 0, data LSB-first, stop 1, each N samples.
  initial begin : monitor
    logic [7:0] eb;
    int         ea, wave_err, hs_err, done_at, done_cnt;
    logic [7:0] got;
    logic       exp_wave [FL];
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst_n && bus.tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 64'd1, 64'd0);
          eb = 8'h00;
          ea = cyc;
        end else begin
          eb = exp_q.pop_front();
          ea = acc_q.pop_front();
        end
        check("start_latency", cyc, ea);
        start_log.push_back(cyc);
        for (int i = 0; i < FL; i++) begin
          if (i < N) exp_wave[i] = 1'b0;
          else if (i >= 9 * N) exp_wave[i] = 1'b1;
          else exp_wave[i] = eb[i / N - 1];
        end
        wave_err = 0; hs_err = 0; done_at = -1; done_cnt = 0; got = 8'h00; aborted = 1'b0;
        for (int s = 0; s < FL; s++) begin
          if (s > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (bus.tx !== exp_wave[s]) wave_err++;
          if (bus.ready !== 1'b0 || bus.busy !== 1'b1) hs_err++;
          if (bus.done === 1'b1) begin
            done_cnt++;
            done_at = s;
          end
          if (s >= N && s < 9 * N && (s % N) == N / 2) got[s / N - 1] = bus.tx;
        end
        if (!aborted) begin
          check("frame_byte", got, eb);
          check("wave_errors", wave_err, 0);
          check("busy_in_frame", hs_err, 0);
          check("done_count", done_cnt, 1);
          check("done_pos", done_at, FL - 1);
          @(negedge clk);
          check("ready_after", bus.ready, 1);
          check("tx_idle_after", bus.tx, 1);
          check("done_cleared", bus.done, 0);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit hold);
    int w = 0;
    @(negedge clk);
    bus.data_in = b;
    bus.valid   = 1'b1;
    while (bus.ready !== 1'b1 && w < 4 * FL) begin
      @(negedge clk);
      w++;
    end
    if (bus.ready !== 1'b1) begin
      check("accept_timeout", 64'd0, 64'd1);
      bus.valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(b);
    acc_q.push_back(cyc);
    if (!hold) bus.valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((exp_q.size() != 0 || bus.busy !== 1'b0) && w < 8 * FL) begin
      @(negedge clk);
      w++;
    end
    check("idle_timeout", (exp_q.size() == 0 && bus.busy === 1'b0), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_default();
    logic [9:0] bits;
    bits = {1'b1, 8'hA3, 1'b0};
    @(negedge clk);
    check("def_ready_idle", bus_d.ready, 1);
    bus_d.data_in = 8'hA3;
    bus_d.valid   = 1'b1;
    @(posedge clk);
    #1;
    bus_d.valid   = 1'b0;
    bus_d.data_in = 8'h00;
    for (int s = 0; s <= 10 * ND; s++) begin
      @(negedge clk);
      if (s % ND == ND / 2) check("def_bit", bus_d.tx, bits[s / ND]);
      if (s == 10 * ND - 1) begin
        check("def_done", bus_d.done, 1);
        check("def_busy_end", bus_d.ready, 0);
      end
      if (s == 10 * ND) check("def_ready", bus_d.ready, 1);
    end
  endtask

  initial begin : watchdog
    #(900_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n0;
    bit hold;
    bus.data_in = 8'h00;   bus.valid = 1'b0;
    bus_d.data_in = 8'h00; bus_d.valid = 1'b0;
    #23;
    check("rst_tx", bus.tx, 1);
    check("rst_ready", bus.ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_byte(8'h55, 1'b0);
    wait_idle();

    n0 = start_log.size();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b0);
    wait_idle();
    if (start_log.size() >= n0 + 2)
      check("b2b_gap", start_log[n0 + 1] - start_log[n0], FL + 1);
    else
      check("b2b_frames", start_log.size(), n0 + 2);

    send_byte(8'h34, 1'b0);
    repeat (3 * N) @(negedge clk);
    check("ready_in_data", bus.ready, 0);
    bus.data_in = 8'h12;
    bus.valid   = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    wait_idle();

    send_byte(8'h0F, 1'b0);
    repeat (4 * N + 1) @(negedge clk);
    check("bit3_state", dbg_state, ST_DATA);
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", bus.tx, 1);
    check("abort_ready", bus.ready, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_state", dbg_state, ST_IDLE);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h81, 1'b0);
    wait_idle();

    for (int i = 0; i < 12; i++) begin
      hold = ($urandom_range(0, 3) == 0);
      send_byte(8'($urandom_range(0, 255)), hold);
      if (!hold) repeat ($urandom_range(0, 2 * FL)) @(negedge clk);
    end
    @(negedge clk);
    bus.valid = 1'b0;
    wait_idle();

    check_default();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
